// File: rtl/draw_character.sv
// draw_character: overlays the player sprite onto the background pixel stream.
//
// Two-stage pipeline with a fixed 2-clk latency on every signal:
//   stage 1 - compute sprite hit and ROM address; delay timing/background by 1
//   stage 2 - merge ROM pixel (colour-keyed) with delayed background
//
// Ports:
//   clk, rst_n                         pixel clock, async active-low reset
//   hcount_in/vcount_in, *sync/*blnk  incoming timing
//   rgb_in                             background pixel
//   xpos/ypos/facing_left/char_state_in  sprite placement, latched at (0,0)
//   rom_addr/rom_state                 sprite ROM request (registered)
//   rom_rgb                            sprite ROM data for the current rom_addr
//   hcount_out.. vblnk_out, rgb_out    timing delayed 2 clk, merged pixel
module draw_character #(
  parameter int          SPR_W   = 48,
  parameter int          SPR_H   = 64,
  parameter logic [11:0] KEY_RGB = 12'hF0F
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] hcount_in,
  input  logic [10:0] vcount_in,
  input  logic        hsync_in,
  input  logic        hblnk_in,
  input  logic        vsync_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_in,
  input  logic [10:0] xpos,
  input  logic [10:0] ypos,
  input  logic        facing_left,
  input  logic [1:0]  char_state_in,
  output logic [11:0] rom_addr,
  output logic [1:0]  rom_state,
  input  logic [11:0] rom_rgb,
  output logic [10:0] hcount_out,
  output logic [10:0] vcount_out,
  output logic        hsync_out,
  output logic        hblnk_out,
  output logic        vsync_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out
);

  localparam int CW = $clog2(SPR_W);
  localparam int RW = $clog2(SPR_H);
  localparam logic [CW-1:0] COL_MAX = CW'(SPR_W - 1);

  // frame-latched sprite parameters
  logic [10:0] xl_q, xl_d, yl_q, yl_d;
  logic        fl_q, fl_d;
  logic [1:0]  sl_q, sl_d;

  // stage 1
  logic [11:0] rom_addr_q, rom_addr_d;
  logic [1:0]  rom_state_q, rom_state_d;
  logic        inside_s1_q, inside_s1_d;
  logic [10:0] hcount_s1_q, vcount_s1_q;
  logic        hsync_s1_q, hblnk_s1_q, vsync_s1_q, vblnk_s1_q;
  logic [11:0] rgb_s1_q;

  // stage 2
  logic [10:0] hcount_out_q, vcount_out_q;
  logic        hsync_out_q, hblnk_out_q, vsync_out_q, vblnk_out_q;
  logic [11:0] rgb_out_q, rgb_out_d;

  logic          origin;
  logic [11:0]   h12, v12, x12, y12;
  logic [CW-1:0] col_raw, col;
  logic [RW-1:0] row;

  always_comb begin
    origin = (hcount_in == 11'd0) && (vcount_in == 11'd0);

    // The origin pixel itself already uses the newly sampled values, so the
    // whole frame is drawn with one consistent set.
    xl_d = origin ? xpos        : xl_q;
    yl_d = origin ? ypos        : yl_q;
    fl_d = origin ? facing_left : fl_q;
    sl_d = sl_q;
    if (origin) sl_d = (char_state_in == 2'b11) ? 2'b00 : char_state_in;

    // 12-bit compare so xl+SPR_W / yl+SPR_H cannot wrap; the sprite clips.
    h12 = {1'b0, hcount_in};
    v12 = {1'b0, vcount_in};
    x12 = {1'b0, xl_d};
    y12 = {1'b0, yl_d};
    inside_s1_d = (h12 >= x12) && (h12 < x12 + 12'(SPR_W)) &&
                  (v12 >= y12) && (v12 < y12 + 12'(SPR_H));

    // Only the low bits of the offsets matter once inside is known.
    col_raw = hcount_in[CW-1:0] - xl_d[CW-1:0];
    row     = vcount_in[RW-1:0] - yl_d[RW-1:0];
    col     = fl_d ? (COL_MAX - col_raw) : col_raw;

    rom_addr_d  = inside_s1_d ? (12'(row) * 12'(SPR_W) + 12'(col)) : 12'd0;
    rom_state_d = sl_d;

    rgb_out_d = (inside_s1_q && (rom_rgb != KEY_RGB)) ? rom_rgb : rgb_s1_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xl_q         <= '0;
      yl_q         <= '0;
      fl_q         <= 1'b0;
      sl_q         <= '0;
      rom_addr_q   <= '0;
      rom_state_q  <= '0;
      inside_s1_q  <= 1'b0;
      hcount_s1_q  <= '0;
      vcount_s1_q  <= '0;
      hsync_s1_q   <= 1'b0;
      hblnk_s1_q   <= 1'b0;
      vsync_s1_q   <= 1'b0;
      vblnk_s1_q   <= 1'b0;
      rgb_s1_q     <= '0;
      hcount_out_q <= '0;
      vcount_out_q <= '0;
      hsync_out_q  <= 1'b0;
      hblnk_out_q  <= 1'b0;
      vsync_out_q  <= 1'b0;
      vblnk_out_q  <= 1'b0;
      rgb_out_q    <= '0;
    end else begin
      xl_q         <= xl_d;
      yl_q         <= yl_d;
      fl_q         <= fl_d;
      sl_q         <= sl_d;
      rom_addr_q   <= rom_addr_d;
      rom_state_q  <= rom_state_d;
      inside_s1_q  <= inside_s1_d;
      hcount_s1_q  <= hcount_in;
      vcount_s1_q  <= vcount_in;
      hsync_s1_q   <= hsync_in;
      hblnk_s1_q   <= hblnk_in;
      vsync_s1_q   <= vsync_in;
      vblnk_s1_q   <= vblnk_in;
      rgb_s1_q     <= rgb_in;
      hcount_out_q <= hcount_s1_q;
      vcount_out_q <= vcount_s1_q;
      hsync_out_q  <= hsync_s1_q;
      hblnk_out_q  <= hblnk_s1_q;
      vsync_out_q  <= vsync_s1_q;
      vblnk_out_q  <= vblnk_s1_q;
      rgb_out_q    <= rgb_out_d;
    end
  end

  assign rom_addr   = rom_addr_q;
  assign rom_state  = rom_state_q;
  assign hcount_out = hcount_out_q;
  assign vcount_out = vcount_out_q;
  assign hsync_out  = hsync_out_q;
  assign hblnk_out  = hblnk_out_q;
  assign vsync_out  = vsync_out_q;
  assign vblnk_out  = vblnk_out_q;
  assign rgb_out    = rgb_out_q;

endmodule

// File: tb/tb_draw_character.sv
module tb_draw_character;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] hcount_in, vcount_in, xpos, ypos;
  logic        hsync_in, hblnk_in, vsync_in, vblnk_in, facing_left;
  logic [11:0] rgb_in, rom_rgb, rom_addr, rgb_out;
  logic [1:0]  char_state_in, rom_state;
  logic [10:0] hcount_out, vcount_out;
  logic        hsync_out, hblnk_out, vsync_out, vblnk_out;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [11:0] addr;
    logic [1:0]  st;
  } s1_t;

  typedef struct packed {
    logic [10:0] hc;
    logic [10:0] vc;
    logic [3:0]  strb;
    logic [11:0] rgb;
  } out_t;

  s1_t  q1[$];
  out_t q2[$];

  // model of the frame latch
  int       mx, my;
  bit       mf;
  bit [1:0] ms;

  draw_character dut (
    .clk(clk), .rst_n(rst_n),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .hblnk_in(hblnk_in), .vsync_in(vsync_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in), .xpos(xpos), .ypos(ypos),
    .facing_left(facing_left), .char_state_in(char_state_in),
    .rom_addr(rom_addr), .rom_state(rom_state), .rom_rgb(rom_rgb),
    .hcount_out(hcount_out), .vcount_out(vcount_out),
    .hsync_out(hsync_out), .hblnk_out(hblnk_out), .vsync_out(vsync_out), .vblnk_out(vblnk_out),
    .rgb_out(rgb_out)
  );

  always #5 clk = ~clk;

  // Sprite ROM model: address 200 holds the key colour, 201 holds 12'h123,
  // everything else addr+state (max 3073, never equal to the key).
  function automatic logic [11:0] rom_f(input logic [11:0] a, input logic [1:0] s);
    if (a == 12'd200) return 12'hF0F;
    if (a == 12'd201) return 12'h123;
    return a + {10'd0, s};
  endfunction

  assign rom_rgb = rom_f(rom_addr, rom_state);

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic [10:0] h, input logic [10:0] v);
    s1_t  e1, g1;
    out_t e2, g2;
    int   dx, dy, col;
    bit   ins;
    logic [11:0] rv;
    hcount_in = h;
    vcount_in = v;
    rgb_in    = 12'($urandom);
    {hsync_in, hblnk_in, vsync_in, vblnk_in} = 4'($urandom);
    if (h == 0 && v == 0) begin
      mx = int'(xpos);
      my = int'(ypos);
      mf = facing_left;
      ms = (char_state_in == 2'b11) ? 2'b00 : char_state_in;
    end
    dx  = int'(h) - mx;
    dy  = int'(v) - my;
    ins = (dx >= 0) && (dx < 48) && (dy >= 0) && (dy < 64);
    col = mf ? 47 - dx : dx;
    e1.addr = ins ? 12'(dy * 48 + col) : 12'd0;
    e1.st   = ms;
    rv      = rom_f(e1.addr, ms);
    e2.hc   = h;
    e2.vc   = v;
    e2.strb = {hsync_in, hblnk_in, vsync_in, vblnk_in};
    e2.rgb  = (ins && rv != 12'hF0F) ? rv : rgb_in;
    q1.push_back(e1);
    q2.push_back(e2);
    @(posedge clk);
    #1;
    e1 = q1.pop_front();
    g1 = '{rom_addr, rom_state};
    check_eq("rom_addr", g1.addr, e1.addr);
    check_eq("rom_state", g1.st, e1.st);
    if (q2.size() >= 2) begin
      e2 = q2.pop_front();
      g2 = '{hcount_out, vcount_out, {hsync_out, hblnk_out, vsync_out, vblnk_out}, rgb_out};
      check_eq("hcount_out", g2.hc, e2.hc);
      check_eq("vcount_out", g2.vc, e2.vc);
      check_eq("strobes_out", g2.strb, e2.strb);
      check_eq("rgb_out", g2.rgb, e2.rgb);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq(tag, {rom_addr, rom_state, hcount_out, vcount_out, hsync_out, hblnk_out,
                   vsync_out, vblnk_out, rgb_out}, 64'd0);
  endtask

  task automatic after_reset();
    mx = 0; my = 0; mf = 0; ms = 0;
    q1.delete();
    q2.delete();
    q2.push_back('0);
  endtask

  task automatic set_pos(input int x, input int y, input bit f, input logic [1:0] s);
    xpos = 11'(x); ypos = 11'(y); facing_left = f; char_state_in = s;
  endtask

  initial begin
    rst_n = 1'b0;
    hcount_in = 11'd5; vcount_in = 11'd7; rgb_in = 12'hABC;
    {hsync_in, hblnk_in, vsync_in, vblnk_in} = 4'hF;
    set_pos(300, 300, 1, 2'b10);
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset_outputs");
    check_eq("reset_rom_state", rom_state, 2'b00);
    rst_n = 1'b1;
    after_reset();

    // latched values are zero until the first origin: sprite at (0,0), state 00
    step(11'd10, 11'd3);
    check_eq("first_out_zero", {hcount_out, rgb_out}, 0);
    for (int i = 0; i < 8; i++) step(11'($urandom_range(1, 100)), 11'($urandom_range(0, 80)));

    // basic placement
    set_pos(100, 50, 0, 2'b00);
    step(11'd0, 11'd0);
    step(11'd100, 11'd50);  check_eq("addr_100_50", rom_addr, 0);
    step(11'd147, 11'd113); check_eq("addr_147_113", rom_addr, 3071);
    step(11'd148, 11'd50);  check_eq("addr_148_50", rom_addr, 0);
    step(11'd99, 11'd50);   check_eq("addr_99_50", rom_addr, 0);
    step(11'd108, 11'd54);  check_eq("addr_key", rom_addr, 200);
    step(11'd109, 11'd54);  check_eq("addr_123", rom_addr, 201);
    step(11'd100, 11'd114); check_eq("rgb_123_lat2", rgb_out, 12'h123);
    step(11'd100, 11'd49);
    step(11'd147, 11'd50);

    // mirrored
    set_pos(100, 50, 1, 2'b00);
    step(11'd0, 11'd0);
    step(11'd100, 11'd50);  check_eq("mirror_100_50", rom_addr, 47);
    step(11'd147, 11'd51);  check_eq("mirror_147_51", rom_addr, 48);

    // mid-frame change ignored until next origin
    set_pos(100, 50, 0, 2'b00);
    step(11'd0, 11'd0);
    set_pos(200, 50, 0, 2'b10);
    step(11'd101, 11'd50);  check_eq("midframe_addr", rom_addr, 1);
    check_eq("midframe_state", rom_state, 2'b00);
    step(11'd201, 11'd50);  check_eq("midframe_new_x", rom_addr, 0);
    step(11'd0, 11'd0);
    step(11'd201, 11'd50);  check_eq("newframe_addr", rom_addr, 1);
    check_eq("newframe_state", rom_state, 2'b10);

    // clipping at the right/bottom edge, state 11 maps to 00
    set_pos(1000, 740, 0, 2'b11);
    step(11'd0, 11'd0);
    check_eq("state11_to_00", rom_state, 2'b00);
    step(11'd1000, 11'd740); check_eq("clip_origin", rom_addr, 0);
    step(11'd1023, 11'd767); check_eq("clip_corner", rom_addr, 1319);
    step(11'd10, 11'd740);   check_eq("clip_no_wrap_x", rom_addr, 0);
    step(11'd1010, 11'd10);  check_eq("clip_no_wrap_y", rom_addr, 0);
    step(11'd20, 11'd20);

    // random frames
    for (int f = 0; f < 6; f++) begin
      set_pos($urandom_range(0, 200), $urandom_range(0, 200), 1'($urandom), 2'($urandom));
      step(11'd0, 11'd0);
      for (int i = 0; i < 60; i++) begin
        logic [10:0] h, v;
        h = 11'($urandom_range(0, 260));
        v = 11'($urandom_range(0, 280));
        if (h == 0 && v == 0) h = 11'd1;
        if (i == 20) set_pos($urandom_range(0, 200), $urandom_range(0, 200), 1'($urandom), 2'($urandom));
        step(h, v);
      end
    end

    // reset mid-frame clears at once; latched values drop to zero
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset_outputs");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    after_reset();
    set_pos(400, 400, 1, 2'b01);
    step(11'd5, 11'd5);   check_eq("post_reset_latch", rom_addr, 245);
    for (int i = 0; i < 6; i++) step(11'($urandom_range(1, 60)), 11'($urandom_range(0, 70)));
    step(11'd0, 11'd0);
    step(11'd400, 11'd400); check_eq("post_reset_newframe", rom_addr, 47);
    step(11'd1, 11'd1);
    step(11'd2, 11'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
